// File: rtl/adc_stream_framer.sv
// adc_stream_framer: frames a non-stallable ADC sample stream into AXI4-Stream
// packets of FRAME_LEN beats, buffered through a FIFO_DEPTH-entry FIFO.
// Optional build macro ADC_FRAMER_HDR_EN: each frame is preceded by one header
// beat carrying a 16-bit frame sequence number (0xA5C0 tag in the upper bits
// when TDATA_WIDTH >= 32).
module adc_stream_framer #(
   parameter int DATA_WIDTH  = 16,
   parameter int TDATA_WIDTH = 16,
   parameter int FRAME_LEN   = 256,
   parameter int FIFO_DEPTH  = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   ovf_clr,
   input  logic [DATA_WIDTH-1:0]  adc_data,
   input  logic                   adc_valid,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   overflow,
   output logic [15:0]            drop_cnt,
   output logic                   busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(FRAME_LEN);
   localparam int EW = TDATA_WIDTH + 1;   // {tlast, tdata}
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     occ_q, occ_d;           // samples held in memory + output register
   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic            out_valid_q, out_valid_d;
   logic [TDATA_WIDTH-1:0] out_data_q, out_data_d;
   logic            out_last_q, out_last_d;
   logic            ovf_q, ovf_d;
   logic [15:0]     drop_q, drop_d;

   logic            wr_allow, full, wr_req, wr_en, drop, wr_last;
   logic            mem_empty, xfer, load_ok, pop, data_xfer;
   logic [EW-1:0]   wr_entry, rd_entry;

`ifdef ADC_FRAMER_HDR_EN
   localparam int HDR_SH = (TDATA_WIDTH >= 32) ? TDATA_WIDTH - 16 : 0;
   localparam logic [TDATA_WIDTH-1:0] HDR_TAG =
      (TDATA_WIDTH >= 32) ? (TDATA_WIDTH'(16'hA5C0) << HDR_SH) : '0;
   logic [15:0]     seq_q, seq_d;
   logic            hdr_sent_q, hdr_sent_d;   // header of the current frame already loaded
   logic            out_hdr_q, out_hdr_d;     // output register holds a header beat
   logic            hdr_load;
`endif

   // Write side: framing state, sample index, drop detection and FIFO write.
   // Full is judged on the registered occupancy, so a same-cycle read never
   // rescues a write into a full FIFO.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wr_allow = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (enable) begin
               wr_allow = 1'b1;
            end else if (idx_q != '0) begin
               wr_allow = 1'b1;
               state_d  = ST_DRAIN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_DRAIN: wr_allow = 1'b1;
         default:  state_d  = ST_IDLE;
      endcase
      full     = (occ_q == FULL_CNT);
      wr_req   = wr_allow & adc_valid;
      wr_en    = wr_req & ~full;
      drop     = wr_req & full;
      wr_last  = (idx_q == LAST_IDX);
      wr_entry = {wr_last, TDATA_WIDTH'($signed(adc_data))};
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      if (wr_en) begin
         idx_d = wr_last ? '0 : idx_q + IDX_ONE;
         if (wr_last && state_d == ST_DRAIN) state_d = ST_IDLE;
      end
   end

   // Read side: registered output stage refilled from the FIFO head.
   // Handshake: a beat transfers on tvalid & tready; once tvalid is high it
   // stays high with tdata/tlast frozen until that transfer happens.
   always_comb begin
      xfer        = out_valid_q & m_axis_tready;
      load_ok     = ~out_valid_q | m_axis_tready;
      mem_empty   = (wr_ptr_q == rd_ptr_q);
      rd_entry    = mem[rd_ptr_q[AW-1:0]];
      out_valid_d = out_valid_q & ~m_axis_tready;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      rd_ptr_d    = rd_ptr_q;
`ifdef ADC_FRAMER_HDR_EN
      seq_d       = (xfer && out_last_q) ? seq_q + 16'd1 : seq_q;
      hdr_sent_d  = hdr_sent_q;
      out_hdr_d   = out_hdr_q;
      hdr_load    = load_ok & ~mem_empty & ~hdr_sent_q;
      pop         = load_ok & ~mem_empty & hdr_sent_q;
      data_xfer   = xfer & ~out_hdr_q;
      if (hdr_load) begin
         out_valid_d = 1'b1;
         out_data_d  = HDR_TAG | TDATA_WIDTH'(seq_d);
         out_last_d  = 1'b0;
         out_hdr_d   = 1'b1;
         hdr_sent_d  = 1'b1;
      end
      if (pop) begin
         out_hdr_d = 1'b0;
         if (rd_entry[EW-1]) hdr_sent_d = 1'b0;
      end
`else
      pop         = load_ok & ~mem_empty;
      data_xfer   = xfer;
`endif
      if (pop) begin
         out_valid_d = 1'b1;
         out_data_d  = rd_entry[TDATA_WIDTH-1:0];
         out_last_d  = rd_entry[EW-1];
         rd_ptr_d    = rd_ptr_q + PTR_ONE;
      end
   end

   // Occupancy bookkeeping plus sticky overflow flag and saturating drop counter.
   always_comb begin
      occ_d = occ_q;
      if (wr_en && !data_xfer)      occ_d = occ_q + PTR_ONE;
      else if (!wr_en && data_xfer) occ_d = occ_q - PTR_ONE;
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (ovf_clr) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end
      if (drop) begin
         ovf_d  = 1'b1;
         if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         ovf_q       <= 1'b0;
         drop_q      <= '0;
`ifdef ADC_FRAMER_HDR_EN
         seq_q       <= '0;
         hdr_sent_q  <= 1'b0;
         out_hdr_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         ovf_q       <= ovf_d;
         drop_q      <= drop_d;
`ifdef ADC_FRAMER_HDR_EN
         seq_q       <= seq_d;
         hdr_sent_q  <= hdr_sent_d;
         out_hdr_q   <= out_hdr_d;
`endif
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
   end

   assign m_axis_tdata  = out_data_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;
   assign overflow      = ovf_q;
   assign drop_cnt      = drop_q;
   assign busy          = (state_q != ST_IDLE) | (occ_q != '0);

endmodule
